// File: rtl/mul_div_pkg.sv
// rtl/mul_div_pkg.sv - shared op encodings, FSM states and counter sizing for mul_div_unit
package mul_div_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int DEFAULT_WIDTH = 32;
    localparam int CNT_W         = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/mul_div_addsub.sv
// rtl/mul_div_addsub.sv - shared WIDTH+1-bit adder/subtractor; carry high on subtract means no borrow
module mul_div_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] x,
    input  logic [WIDTH:0] y,
    input  logic           sub,
    output logic [WIDTH:0] sum,
    output logic           carry
);

    logic [WIDTH+1:0] full;

    assign full  = {1'b0, x} + {1'b0, (sub ? ~y : y)} + {{(WIDTH + 1){1'b0}}, sub};
    assign sum   = full[WIDTH:0];
    assign carry = full[WIDTH+1];

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative HI/LO multiply/divide unit; divide path enabled by MUL_DIV_UNIT_DIV_EN
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             we_hi,
    input  logic             we_lo,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = cnt_width(WIDTH);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               sign_a;
    logic               sign_b;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     as_x;
    logic [WIDTH:0]     as_y;
    logic               as_sub;
    logic [WIDTH:0]     as_sum;
    logic               as_carry;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

`ifdef MUL_DIV_UNIT_DIV_EN
    logic               is_div;
    logic [WIDTH-1:0]   a_raw;
    logic               dz_q;
`else
    logic               unused_carry;
    assign unused_carry = as_carry;
`endif

    assign mag_a = (op[0] && a[WIDTH-1]) ? -a : a;
    assign mag_b = (op[0] && b[WIDTH-1]) ? -b : b;
    assign busy  = (state == CALC) || (state == FIX);
    assign done  = (state == DONE);

    // Multiply adds the multiplicand into the upper half when the LSB is set;
    // divide trial-subtracts the divisor from the shifted partial remainder.
    always_comb begin
        as_x   = {1'b0, acc[2*WIDTH-1:WIDTH]};
        as_y   = acc[0] ? {1'b0, opnd} : '0;
        as_sub = 1'b0;
`ifdef MUL_DIV_UNIT_DIV_EN
        if (is_div) begin
            as_x   = acc[2*WIDTH-1:WIDTH-1];
            as_y   = {1'b0, opnd};
            as_sub = 1'b1;
        end
`endif
    end

    mul_div_addsub #(.WIDTH(WIDTH)) u_addsub (
        .x     (as_x),
        .y     (as_y),
        .sub   (as_sub),
        .sum   (as_sum),
        .carry (as_carry)
    );

    always_comb begin
        prod   = (sign_a ^ sign_b) ? -acc : acc;
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
`ifdef MUL_DIV_UNIT_DIV_EN
        if (is_div) begin
            if (opnd == '0) begin
                fix_hi = a_raw;
                fix_lo = '1;
            end else begin
                fix_lo = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                fix_hi = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            hi     <= '0;
            lo     <= '0;
`ifdef MUL_DIV_UNIT_DIV_EN
            is_div <= 1'b0;
            a_raw  <= '0;
            dz_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_a <= op[0] & a[WIDTH-1];
                        sign_b <= op[0] & b[WIDTH-1];
                        cnt    <= '0;
`ifdef MUL_DIV_UNIT_DIV_EN
                        is_div <= op[1];
                        a_raw  <= a;
                        dz_q   <= 1'b0;
                        acc    <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
                        opnd   <= op[1] ? mag_b : mag_a;
                        state  <= CALC;
`else
                        acc    <= {{WIDTH{1'b0}}, mag_b};
                        opnd   <= mag_a;
                        state  <= op[1] ? DONE : CALC;
`endif
                    end else begin
                        if (we_hi) hi <= wd;
                        if (we_lo) lo <= wd;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    acc <= {as_sum, acc[WIDTH-1:1]};
`ifdef MUL_DIV_UNIT_DIV_EN
                    if (is_div) begin
                        acc <= as_carry ? {as_sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                                        : {acc[2*WIDTH-2:0], 1'b0};
                    end
`endif
                    if (cnt == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
`ifdef MUL_DIV_UNIT_DIV_EN
                    if (is_div && opnd == '0) dz_q <= 1'b1;
`endif
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MUL_DIV_UNIT_DIV_EN
    assign div_zero = dz_q;
`else
    assign div_zero = 1'b0;
`endif

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Sequential multiply/divide unit that owns the HI/LO register pair. Sits directly downstream of the register-file read ports: it takes rs/rt operand values and produces HI/LO for the mfhi/mflo write-back mux. It replaces the single-cycle combinational multiplier and adds mult/multu/div/divu plus mthi/mtlo. It runs iteratively, one bit per cycle, and exposes a busy/done handshake so control can stall on mfhi/mflo while an operation is in flight.

## Interface
- WIDTH, 32, operand and HI/LO width.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  launch request; sampled only in IDLE.
- op  in  2  operation select: 00 multu, 01 mult, 10 divu, 11 div.
- a  in  WIDTH  rs operand (multiplicand / dividend).
- b  in  WIDTH  rt operand (multiplier / divisor).
- we_hi  in  1  mthi write strobe.
- we_lo  in  1  mtlo write strobe.
- wd  in  WIDTH  mthi/mtlo write data.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- div_zero  out  1  sticky flag, set by a divide with b==0 and cleared by the next accepted start.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- **States and transitions**
  - IDLE: on start, latch operand magnitudes and sign bits, clear the counter, then go to CALC.
  - CALC: WIDTH iterations, then go to FIX.
  - FIX: apply signs and write HI/LO, then go to DONE.
  - DONE: assert done, then return to IDLE.
- **Signed ops (mult, div)**: operands are converted to magnitude at launch. |-2^(WIDTH-1)| is held as an unsigned WIDTH-bit value.
- **Multiply**: radix-2 shift-add over a 2*WIDTH-bit accumulator.
  - Signed result is negated if sign(a) XOR sign(b).
  - {hi,lo} = 2*WIDTH-bit product.
- **Divide**: restoring division.
  - lo = quotient, hi = remainder.
  - Signed: quotient is negated if the signs differ; remainder takes the sign of the dividend.
- **Divide by zero**: the iterations still run.
  - Result is forced to hi = a, lo = all ones.
  - div_zero is set.
- **Signed overflow** (0x80000000 / 0xFFFFFFFF): lo = 0x80000000, hi = 0. No flag.
- **mthi/mtlo**: written from wd at the next edge, only in IDLE.
  - Ignored while busy.
  - If start and a write strobe occur in the same IDLE cycle, start wins and the write is discarded.
- **start while busy** (CALC/FIX/DONE): ignored; it is not queued.

## Timing
- **Reset values**: hi=0, lo=0, busy=0, done=0, div_zero=0, state IDLE.
- **Latency**: with start accepted at edge T:
  - busy is high for cycles T+1 to T+WIDTH+1.
  - hi/lo update at edge T+WIDTH+2.
  - done is high during cycle T+WIDTH+2, and busy is low in that cycle.
  - Start to done = WIDTH+2 = 34 cycles.
- **Back-to-back**: a new start is accepted in the IDLE cycle immediately after DONE. Minimum issue interval is WIDTH+3 cycles.
- **Operand latching**: a/b/op are captured only at acceptance, so later changes are ignored.
- **Reset mid-operation**: the next edge with rst low returns to IDLE with all outputs at reset values. The in-flight result is lost.
- hi/lo are stable at all times except at the FIX→DONE edge and on mthi/mtlo edges.

## Configuration
- Macro: MUL_DIV_UNIT_DIV_EN.
- **Defined**: full behaviour above.
- **Undefined**: divide datapath is removed and div_zero is tied 0.
  - A start with op[1]=1 is accepted as a no-op: busy stays low, done pulses the following cycle, and hi/lo are unchanged.
  - Multiply timing is identical.

## Structure
- **Package mul_div_pkg** holds:
  - op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV);
  - the state enum (IDLE, CALC, FIX, DONE);
  - the counter width constant, clog2(WIDTH)+1.
- **Sub-module mul_div_addsub**: a shared WIDTH+1-bit adder/subtractor. Multiply uses it for add; divide uses it for the trial subtract, with carry-out as the restore decision.

## Test plan
- multu a=0xFFFFFFFF b=0xFFFFFFFF → done exactly 34 cycles after start; hi=0xFFFFFFFE, lo=0x00000001; busy high for 33 cycles.
- mult a=-3 b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. div a=-7 b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=100 b=7 → lo=14, hi=2.
- divu a=5 b=0 → hi=5, lo=0xFFFFFFFF, div_zero=1. Next multu start clears div_zero.
- div a=0x80000000 b=0xFFFFFFFF → lo=0x80000000, hi=0, div_zero=0.
- mthi wd=0x1234 in IDLE → hi=0x1234 next cycle. mtlo during busy → lo unchanged. start+we_hi together → op runs and the write is dropped.
- rst low at cycle 10 of a multu → busy=0, hi=lo=0. A second start during busy is ignored. A fresh start afterwards completes correctly in 34 cycles.
